// File: rtl/vga_plot_scheduler_pkg.sv
// Shared widths, colour constants, state encoding and clip helper for the
// VGA plot scheduler.
package vga_plot_scheduler_pkg;

    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int C_W          = 3;
    localparam int CNT_W        = 4;
    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;

    localparam logic [C_W-1:0] COLOUR_BLACK = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        LATCH,
        SWEEP,
        DONE
    } state_t;

    // Sums arrive one bit wider than the screen coordinate so off-screen pixels never alias back on.
    function automatic logic onScreen(input logic [X_W:0] xSum, input logic [Y_W:0] ySum,
                                      input int xMax, input int yMax);
        return (xSum <= (X_W+1)'(xMax)) && (ySum <= (Y_W+1)'(yMax));
    endfunction

endpackage

// File: rtl/vga_plot_scheduler_if.sv
// Request/grant bundle from the sprite FSMs plus the pixel-write port to the VGA adapter.
interface vga_plot_scheduler_if
    import vga_plot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2
) ();

    logic [NUM_REQ-1:0]     req;
    logic [X_W*NUM_REQ-1:0] req_x;
    logic [Y_W*NUM_REQ-1:0] req_y;
    logic [C_W*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]     req_erase;
    logic [NUM_REQ-1:0]     grant;
    logic [NUM_REQ-1:0]     done;
    logic                   busy;
    logic [X_W-1:0]         oX;
    logic [Y_W-1:0]         oY;
    logic [C_W-1:0]         oColour;
    logic                   oPlot;

    modport master (
        output req, req_x, req_y, req_colour, req_erase,
        input  grant, done, busy, oX, oY, oColour, oPlot
    );

    modport slave (
        input  req, req_x, req_y, req_colour, req_erase,
        output grant, done, busy, oX, oY, oColour, oPlot
    );

endinterface

// File: rtl/vga_plot_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1.
module vga_plot_scheduler_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int   cand;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = IDX_W'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/vga_plot_scheduler.sv
// Shares the VGA pixel-write port between NUM_REQ box drawers, sweeping the
// winner's box row-major and pulsing done when it completes.
module vga_plot_scheduler
    import vga_plot_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BOX_W   = 4,
    parameter int BOX_H   = 4,
    parameter int X_MAX   = SCREEN_X_MAX,
    parameter int Y_MAX   = SCREEN_Y_MAX
) (
    input logic                  clock,
    input logic                  reset,
    vga_plot_scheduler_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state_q;
    logic [IDX_W-1:0]   gIdx_q, ptr_q;
    logic [X_W-1:0]     x0_q, oX_q;
    logic [Y_W-1:0]     y0_q, oY_q;
    logic [C_W-1:0]     colour_q, oColour_q;
    logic [CNT_W-1:0]   col_q, row_q;
    logic [NUM_REQ-1:0] grant_q, done_q;
    logic               busy_q, oPlot_q;

    logic [NUM_REQ-1:0] arbOneHot;
    logic [IDX_W-1:0]   arbIdx;
    logic               arbValid;

    logic               lastCol, lastRow;
    logic [CNT_W-1:0]   col_d, row_d, offCol, offRow;
    logic [X_W-1:0]     baseX;
    logic [Y_W-1:0]     baseY;
    logic [C_W-1:0]     colour_d;
    logic [X_W:0]       xSum;
    logic [Y_W:0]       ySum;

    vga_plot_scheduler_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .grant_o (arbOneHot),
        .idx_o   (arbIdx),
        .valid_o (arbValid)
    );

    // In LATCH the first pixel comes straight from the winner's inputs; in SWEEP from the latched origin.
    always_comb begin
        lastCol = (col_q == CNT_W'(BOX_W - 1));
        lastRow = (row_q == CNT_W'(BOX_H - 1));
        col_d   = lastCol ? '0 : col_q + 1'b1;
        row_d   = lastCol ? row_q + 1'b1 : row_q;
        if (state_q == LATCH) begin
            baseX    = bus.req_x[X_W*gIdx_q +: X_W];
            baseY    = bus.req_y[Y_W*gIdx_q +: Y_W];
            colour_d = bus.req_erase[gIdx_q] ? COLOUR_BLACK : bus.req_colour[C_W*gIdx_q +: C_W];
            offCol   = '0;
            offRow   = '0;
        end else begin
            baseX    = x0_q;
            baseY    = y0_q;
            colour_d = colour_q;
            offCol   = col_d;
            offRow   = row_d;
        end
        xSum = {1'b0, baseX} + (X_W+1)'(offCol);
        ySum = {1'b0, baseY} + (Y_W+1)'(offRow);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            gIdx_q    <= '0;
            ptr_q     <= IDX_W'(NUM_REQ - 1);
            x0_q      <= '0;
            y0_q      <= '0;
            colour_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            oX_q      <= '0;
            oY_q      <= '0;
            oColour_q <= '0;
            oPlot_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q  <= '0;
                    oPlot_q <= 1'b0;
                    if (arbValid) begin
                        state_q <= LATCH;
                        gIdx_q  <= arbIdx;
                        grant_q <= arbOneHot;
                        busy_q  <= 1'b1;
                    end
                end
                LATCH: begin
                    x0_q      <= baseX;
                    y0_q      <= baseY;
                    colour_q  <= colour_d;
                    col_q     <= '0;
                    row_q     <= '0;
                    oX_q      <= xSum[X_W-1:0];
                    oY_q      <= ySum[Y_W-1:0];
                    oColour_q <= colour_d;
                    oPlot_q   <= onScreen(xSum, ySum, X_MAX, Y_MAX);
                    state_q   <= SWEEP;
                end
                SWEEP: begin
                    if (lastCol && lastRow) begin
                        state_q <= DONE;
                        oPlot_q <= 1'b0;
                        done_q  <= grant_q;
                    end else begin
                        col_q     <= col_d;
                        row_q     <= row_d;
                        oX_q      <= xSum[X_W-1:0];
                        oY_q      <= ySum[Y_W-1:0];
                        oColour_q <= colour_d;
                        oPlot_q   <= onScreen(xSum, ySum, X_MAX, Y_MAX);
                    end
                end
                DONE: begin
                    done_q  <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= gIdx_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant   = grant_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
    assign bus.oX      = oX_q;
    assign bus.oY      = oY_q;
    assign bus.oColour = oColour_q;
    assign bus.oPlot   = oPlot_q;

endmodule

// File: tb/tb_vga_plot_scheduler.sv
// Directed bench for vga_plot_scheduler: 4x4 boxes, two requesters, hand-derived
// pixel sequences, clipping, reset abort and mid-sweep input changes.
module tb_vga_plot_scheduler;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   testsRun = 0;
    int   testsFailed = 0;

    vga_plot_scheduler_if #(.NUM_REQ(2)) bus ();

    vga_plot_scheduler #(
        .NUM_REQ (2),
        .BOX_W   (4),
        .BOX_H   (4),
        .X_MAX   (159),
        .Y_MAX   (119)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] x, input logic [6:0] y,
                                 input logic [2:0] colour, input logic erase);
        bus.req_x[8*idx +: 8]      = x;
        bus.req_y[7*idx +: 7]      = y;
        bus.req_colour[3*idx +: 3] = colour;
        bus.req_erase[idx]         = erase;
    endtask

    // Called on a falling edge just before the IDLE cycle that sees the request.
    // If disturbAt >= 0, requester g's x is changed and its req dropped during that pixel.
    task automatic expectBox(input int g, input int x0, input int y0, input logic [2:0] colour,
                             input int disturbAt);
        int x, y;
        logic expPlot;
        @(negedge clock);
        checkOutput("grant", bus.grant, 32'(1 << g));
        checkOutput("busyLatch", bus.busy, 1);
        checkOutput("doneLatch", bus.done, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            x = x0 + (k % 4);
            y = y0 + (k / 4);
            expPlot = (x <= 159) && (y <= 119);
            checkOutput($sformatf("plot%0d", k), bus.oPlot, 32'(expPlot));
            checkOutput($sformatf("doneSweep%0d", k), bus.done, 0);
            if (expPlot) begin
                checkOutput($sformatf("x%0d", k), bus.oX, 32'(x));
                checkOutput($sformatf("y%0d", k), bus.oY, 32'(y));
                checkOutput($sformatf("colour%0d", k), bus.oColour, 32'(colour));
            end
            if (k == disturbAt) begin
                bus.req_x[8*g +: 8] = 8'd99;
                bus.req[g]          = 1'b0;
            end
        end
        @(negedge clock);
        checkOutput("donePulse", bus.done, 32'(1 << g));
        checkOutput("grantDone", bus.grant, 32'(1 << g));
        checkOutput("plotDone", bus.oPlot, 0);
        @(negedge clock);
        checkOutput("grantIdle", bus.grant, 0);
        checkOutput("doneIdle", bus.done, 0);
        checkOutput("busyIdle", bus.busy, 0);
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "Busy"}, bus.busy, 0);
        checkOutput({tag, "Grant"}, bus.grant, 0);
        checkOutput({tag, "Done"}, bus.done, 0);
        checkOutput({tag, "Plot"}, bus.oPlot, 0);
    endtask

    initial begin
        bus.req        = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_colour = '0;
        bus.req_erase  = '0;
        repeat (3) @(negedge clock);
        checkQuiet("reset");
        checkOutput("resetX", bus.oX, 0);
        checkOutput("resetY", bus.oY, 0);
        checkOutput("resetColour", bus.oColour, 0);
        reset = 1'b0;

        // Test 1: plain draw.
        applyStimulus(0, 8'd10, 7'd20, 3'b110, 1'b0);
        bus.req = 2'b01;
        expectBox(0, 10, 20, 3'b110, -1);
        bus.req = 2'b00;

        // Test 2: erase of the same box.
        applyStimulus(0, 8'd10, 7'd20, 3'b110, 1'b1);
        bus.req = 2'b01;
        expectBox(0, 10, 20, 3'b000, -1);
        bus.req = 2'b00;

        // Test 3: both held after reset alternate 0,1,0,1.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(0, 8'd10, 7'd20, 3'b110, 1'b0);
        applyStimulus(1, 8'd40, 7'd50, 3'b011, 1'b0);
        bus.req = 2'b11;
        expectBox(0, 10, 20, 3'b110, -1);
        expectBox(1, 40, 50, 3'b011, -1);
        expectBox(0, 10, 20, 3'b110, -1);
        expectBox(1, 40, 50, 3'b011, -1);
        bus.req = 2'b00;

        // Test 4: bottom-right corner clipping.
        applyStimulus(1, 8'd158, 7'd118, 3'b101, 1'b0);
        bus.req = 2'b10;
        expectBox(1, 158, 118, 3'b101, -1);
        bus.req = 2'b00;

        // Test 5: reset during pixel 7 aborts; requester 0 wins afterwards.
        applyStimulus(0, 8'd30, 7'd40, 3'b111, 1'b0);
        applyStimulus(1, 8'd60, 7'd70, 3'b001, 1'b0);
        bus.req = 2'b01;
        repeat (9) @(negedge clock);
        checkOutput("abortPixel7X", bus.oX, 33);
        checkOutput("abortPixel7Y", bus.oY, 41);
        reset = 1'b1;
        @(negedge clock);
        checkQuiet("abort");
        reset   = 1'b0;
        bus.req = 2'b11;
        expectBox(0, 30, 40, 3'b111, -1);
        bus.req = 2'b00;
        repeat (2) @(negedge clock);
        checkQuiet("afterAbort");

        // Test 6: x change and dropped req mid-sweep are ignored.
        applyStimulus(1, 8'd50, 7'd60, 3'b011, 1'b0);
        bus.req = 2'b10;
        expectBox(1, 50, 60, 3'b011, 5);
        bus.req = 2'b00;
        repeat (2) @(negedge clock);
        checkQuiet("final");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
